// File: rtl/hazard_pkg.sv
// hazard_pkg: shared register-id constants and hazard sequencer states.
package hazard_pkg;
    localparam int REGID_W = 4;
    localparam logic [REGID_W-1:0] REG_ZERO = 4'b0000;
    typedef enum logic [1:0] {RUN, LU, MC} state_t;
endpackage

// File: rtl/hazard_stall_ctrl_if.sv
// hazard_stall_ctrl_if: pipeline hazard inputs and stall/flush controls.
interface hazard_stall_ctrl_if #(parameter int CNT_W = 16);
    import hazard_pkg::*;
    logic [REGID_W-1:0] IFIDrs;
    logic [REGID_W-1:0] IFIDrt;
    logic [REGID_W-1:0] IDEXrt;
    logic IFIDusesRt;
    logic IDEXmemRead;
    logic IDEXmulti;
    logic mcDone;
    logic branchTaken;
    logic pcWrite;
    logic ifidWrite;
    logic idexWrite;
    logic idexBubble;
    logic ifidFlush;
    logic exmemBubble;
    logic mcStart;
    logic mcErr;
    logic [CNT_W-1:0] stallCnt;
    modport master (
        output IFIDrs, IFIDrt, IDEXrt, IFIDusesRt, IDEXmemRead, IDEXmulti, mcDone, branchTaken,
        input pcWrite, ifidWrite, idexWrite, idexBubble, ifidFlush, exmemBubble, mcStart, mcErr, stallCnt
    );
    modport slave (
        input IFIDrs, IFIDrt, IDEXrt, IFIDusesRt, IDEXmemRead, IDEXmulti, mcDone, branchTaken,
        output pcWrite, ifidWrite, idexWrite, idexBubble, ifidFlush, exmemBubble, mcStart, mcErr, stallCnt
    );
endinterface

// File: rtl/hazard_stall_ctrl_sat_counter.sv
// sat_counter: counter that sticks at all-ones instead of wrapping.
module sat_counter #(parameter int W = 16) (
    input logic clk,
    input logic rst,
    input logic en,
    output logic [W-1:0] q
);
    always_ff @(posedge clk) begin
        if (rst) q <= '0;
        else if (en && q != '1) q <= q + W'(1);
    end
endmodule

// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl: load-use / multi-cycle stall and branch flush sequencer.
module hazard_stall_ctrl
    import hazard_pkg::*;
#(
    parameter int LOAD_STALL = 1,
    parameter int MC_TIMEOUT = 32,
    parameter int CNT_W = 16
) (
    input logic clk,
    input logic rst,
    hazard_stall_ctrl_if.slave hz
);
    localparam int MCW = MC_TIMEOUT > 1 ? $clog2(MC_TIMEOUT) : 1;
    state_t state;
    logic [2:0] lu_cnt;
    logic [MCW-1:0] mc_cnt;
    logic lu_haz, mc_end, run_br, run_mc, run_lu, lu_hold, mc_hold, mc_drop;
    assign lu_haz = hz.IDEXmemRead && hz.IDEXrt != REG_ZERO &&
                    (hz.IDEXrt == hz.IFIDrs || (hz.IFIDusesRt && hz.IDEXrt == hz.IFIDrt));
    assign mc_end = hz.mcDone || mc_cnt == MCW'(MC_TIMEOUT - 1);
    // branch outranks a multi-cycle start, which outranks a load-use stall
    assign run_br = state == RUN && hz.branchTaken;
    assign run_mc = state == RUN && !hz.branchTaken && hz.IDEXmulti;
    assign run_lu = state == RUN && !hz.branchTaken && !hz.IDEXmulti && lu_haz;
    assign lu_hold = state == LU;
    assign mc_hold = state == MC && !mc_end;
    // on timeout the pipeline advances but the unfinished op is bubbled out
    assign mc_drop = state == MC && !hz.mcDone;
    assign hz.pcWrite = !(run_mc || run_lu || lu_hold || mc_hold);
    assign hz.ifidWrite = !(run_mc || run_lu || lu_hold || mc_hold);
    assign hz.idexWrite = !(run_mc || mc_hold);
    assign hz.idexBubble = run_br || run_lu || lu_hold;
    assign hz.ifidFlush = run_br;
    assign hz.exmemBubble = run_mc || mc_drop;
    assign hz.mcStart = run_mc;
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RUN;
            lu_cnt <= '0;
            mc_cnt <= '0;
            hz.mcErr <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    if (run_mc) begin
                        mc_cnt <= '0;
                        state <= MC;
                    end else if (run_lu && LOAD_STALL > 1) begin
                        lu_cnt <= 3'(LOAD_STALL - 1);
                        state <= LU;
                    end
                end
                LU: begin
                    lu_cnt <= lu_cnt - 3'd1;
                    if (lu_cnt == 3'd1) state <= RUN;
                end
                MC: begin
                    mc_cnt <= mc_cnt + MCW'(1);
                    if (mc_end) begin
                        state <= RUN;
                        if (!hz.mcDone) hz.mcErr <= 1'b1;
                    end
                end
                default: state <= RUN;
            endcase
        end
    end
    sat_counter #(.W(CNT_W)) u_cnt (
        .clk(clk),
        .rst(rst),
        .en(!hz.pcWrite),
        .q(hz.stallCnt)
    );
endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// tb_hazard_stall_ctrl: directed vectors into a scoreboard checked by a negedge monitor.
module tb_hazard_stall_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;
    hazard_stall_ctrl_if #(.CNT_W(16)) ia();
    hazard_stall_ctrl_if #(.CNT_W(16)) ib();
    hazard_stall_ctrl #(.LOAD_STALL(1), .MC_TIMEOUT(32), .CNT_W(16)) dut_a (.clk(clk), .rst(rst), .hz(ia.slave));
    hazard_stall_ctrl #(.LOAD_STALL(3), .MC_TIMEOUT(32), .CNT_W(16)) dut_b (.clk(clk), .rst(rst), .hz(ib.slave));
    // control vector: pcWrite ifidWrite idexWrite idexBubble ifidFlush exmemBubble mcStart mcErr
    localparam logic [7:0] DEF = 8'b1110_0000;
    localparam logic [7:0] LUS = 8'b0011_0000;
    localparam logic [7:0] BR  = 8'b1111_1000;
    localparam logic [7:0] MCS = 8'b0000_0110;
    localparam logic [7:0] MCH = 8'b0000_0100;
    localparam logic [7:0] TO  = 8'b1110_0100;
    typedef struct {
        bit b;
        int id;
        logic [7:0] ctl;
        logic [15:0] cnt;
    } exp_t;
    exp_t sb[$];
    int n_cmp = 0;
    int n_bad = 0;
    int step = 0;
    always @(negedge clk) begin
        exp_t e;
        logic [7:0] ac;
        logic [15:0] an;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            ac = e.b ? {ib.pcWrite, ib.ifidWrite, ib.idexWrite, ib.idexBubble, ib.ifidFlush, ib.exmemBubble, ib.mcStart, ib.mcErr}
                     : {ia.pcWrite, ia.ifidWrite, ia.idexWrite, ia.idexBubble, ia.ifidFlush, ia.exmemBubble, ia.mcStart, ia.mcErr};
            an = e.b ? ib.stallCnt : ia.stallCnt;
            n_cmp++;
            if (ac !== e.ctl || an !== e.cnt) begin
                n_bad++;
                $display("FAIL step%0d dut_%s: ctl=%b cnt=%0d, expected ctl=%b cnt=%0d",
                         e.id, e.b ? "b" : "a", ac, an, e.ctl, e.cnt);
            end
        end
    end
    task automatic drive(input bit sel, input bit on, input logic [3:0] rs, input logic [3:0] rt, input logic ut,
                         input logic [3:0] xrt, input logic mr, input logic mu, input logic dn, input logic br);
        if (sel) begin
            ib.IFIDrs = on ? rs : 4'd0; ib.IFIDrt = on ? rt : 4'd0; ib.IFIDusesRt = on && ut;
            ib.IDEXrt = on ? xrt : 4'd0; ib.IDEXmemRead = on && mr; ib.IDEXmulti = on && mu;
            ib.mcDone = on && dn; ib.branchTaken = on && br;
        end else begin
            ia.IFIDrs = on ? rs : 4'd0; ia.IFIDrt = on ? rt : 4'd0; ia.IFIDusesRt = on && ut;
            ia.IDEXrt = on ? xrt : 4'd0; ia.IDEXmemRead = on && mr; ia.IDEXmulti = on && mu;
            ia.mcDone = on && dn; ia.branchTaken = on && br;
        end
    endtask
    task automatic cyc(input bit b, input logic [3:0] rs, input logic [3:0] rt, input logic ut,
                       input logic [3:0] xrt, input logic mr, input logic mu, input logic dn, input logic br,
                       input logic [7:0] ec, input logic [15:0] en);
        exp_t e;
        drive(1'b0, !b, rs, rt, ut, xrt, mr, mu, dn, br);
        drive(1'b1, b, rs, rt, ut, xrt, mr, mu, dn, br);
        e.b = b; e.id = step; e.ctl = ec; e.cnt = en;
        sb.push_back(e);
        step++;
        @(posedge clk);
        #1;
    endtask
    initial begin
        drive(1'b0, 1'b0, 0, 0, 0, 0, 0, 0, 0, 0);
        drive(1'b1, 1'b0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        //  b  rs rt ut xrt mr mu dn br  ctl  cnt
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, DEF, 0);
        cyc(0, 5, 0, 0, 5, 1, 0, 0, 0, LUS, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, DEF, 1);
        cyc(0, 3, 5, 0, 5, 1, 0, 0, 0, DEF, 1);
        cyc(0, 3, 5, 1, 5, 1, 0, 0, 0, LUS, 1);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, DEF, 2);
        cyc(0, 0, 0, 0, 0, 1, 0, 0, 0, DEF, 2);
        cyc(0, 5, 0, 0, 5, 1, 0, 0, 1, BR, 2);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, DEF, 2);
        cyc(0, 0, 0, 0, 0, 0, 1, 0, 0, MCS, 2);
        cyc(0, 0, 0, 0, 0, 0, 1, 0, 0, MCH, 3);
        cyc(0, 0, 0, 0, 0, 0, 1, 0, 0, MCH, 4);
        cyc(0, 0, 0, 0, 0, 0, 1, 0, 1, MCH, 5);
        cyc(0, 0, 0, 0, 0, 0, 1, 0, 0, MCH, 6);
        cyc(0, 0, 0, 0, 0, 0, 1, 0, 0, MCH, 7);
        cyc(0, 0, 0, 0, 0, 0, 1, 1, 0, DEF, 8);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, DEF, 8);
        cyc(0, 0, 0, 0, 0, 0, 1, 0, 0, MCS, 8);
        for (int k = 0; k < 31; k++) cyc(0, 0, 0, 0, 0, 0, 1, 0, 0, MCH, 16'(9 + k));
        cyc(0, 0, 0, 0, 0, 0, 1, 0, 0, TO, 40);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, DEF | 8'd1, 40);
        cyc(0, 7, 0, 0, 7, 1, 0, 0, 0, LUS | 8'd1, 40);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, DEF | 8'd1, 41);
        cyc(0, 0, 0, 0, 0, 0, 1, 0, 0, MCS | 8'd1, 41);
        cyc(0, 0, 0, 0, 0, 0, 1, 0, 0, MCH | 8'd1, 42);
        cyc(0, 0, 0, 0, 0, 0, 1, 0, 0, MCH | 8'd1, 43);
        rst = 1'b1;
        cyc(0, 0, 0, 0, 0, 0, 1, 0, 0, MCH | 8'd1, 44);
        rst = 1'b0;
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, DEF, 0);
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, DEF, 0);
        cyc(1, 2, 7, 1, 7, 1, 0, 0, 0, LUS, 0);
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 1, LUS, 1);
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, LUS, 2);
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, DEF, 3);
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, DEF, 3);
        @(negedge clk);
        #1;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d entries left, expected 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
